// File: rtl/muldiv_unit_if.sv
// Handshake and operand bus for the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  // Requester side (execute stage / testbench)
  modport master (
    output start_i, op_i, a_i, b_i,
    input  busy_o, done_o, result_o
  );

  // Unit side
  modport slave (
    input  start_i, op_i, a_i, b_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2*XLEN accumulator, one bit per cycle, with divide special cases
// resolved directly in PREP.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StPrep, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic              neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept, is_div, sign_a, sign_b, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_step, div_step, acc_step, prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  assign bus.busy_o   = (state_q == StPrep) || (state_q == StCalc);
  assign bus.done_o   = (state_q == StDone);
  assign bus.result_o = result_q;

  // Datapath and next-state logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    accept = bus.start_i && ((state_q == StIdle) || (state_q == StDone));
    is_div = op_q[2];
    // MULH, DIV, REM: both signed; MULHSU: only a signed
    sign_a = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    sign_b = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    a_neg  = sign_a && a_q[XLEN-1];
    b_neg  = sign_b && b_q[XLEN-1];
    mag_a  = a_neg ? -a_q : a_q;
    mag_b  = b_neg ? -b_q : b_q;

    // Multiply: low half holds the remaining multiplier bits
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mag_a_q : '0)};
    mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out, quotient in
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, mag_b_q};
    div_diff  = div_shift - {1'b0, mag_b_q};
    div_step  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

    acc_step = is_div ? div_step : mul_step;

    prod = neg_q ? -acc_step : acc_step;
    quo  = acc_step[XLEN-1:0];
    rem  = acc_step[2*XLEN-1:XLEN];
    if (is_div) begin
      final_res = op_q[1] ? (rem_neg_q ? -rem : rem) : (neg_q ? -quo : quo);
    end else begin
      final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          op_d    = bus.op_i;
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          state_d = StPrep;
        end else begin
          state_d = StIdle;
        end
      end
      StPrep: begin
        mag_a_d   = mag_a;
        mag_b_d   = mag_b;
        neg_d     = a_neg ^ b_neg;
        rem_neg_d = a_neg;
        cnt_d     = '0;
        if (is_div && (b_q == '0)) begin
          result_d = op_q[1] ? a_q : '1;
          state_d  = StDone;
        end else if (is_div && !op_q[0] && (a_q == MostNeg) && (b_q == '1)) begin
          result_d = op_q[1] ? '0 : a_q;
          state_d  = StDone;
        end else begin
          acc_d   = is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          result_d = final_res;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32 main instance, XLEN=8 latency check).
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  muldiv_unit_if #(.XLEN(32)) bus ();
  muldiv_unit_if #(.XLEN(8))  bus8 ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation: accept, scramble inputs, poke start in CALC, time done_o and check result
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    int cyc;
    bit busy_ok;
    bit seen;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.op_i    = op ^ 3'b011;
    bus.a_i     = ~a;
    bus.b_i     = b + 32'd3;
    cyc     = 0;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (!seen && cyc < lat + 20) begin
      @(negedge clk);
      cyc++;
      if (bus.done_o) begin
        seen = 1'b1;
      end else begin
        if (!bus.busy_o) busy_ok = 1'b0;
        if (cyc == 5 && lat > 6) begin
          bus.start_i = 1'b1;
          bus.op_i    = 3'b000;
          bus.a_i     = 32'd1;
          bus.b_i     = 32'd1;
        end
        if (cyc == 6) bus.start_i = 1'b0;
      end
    end
    check($sformatf("%s latency", tag), 64'(cyc), 64'(lat));
    check($sformatf("%s result", tag), 64'(bus.result_o), 64'(exp));
    check($sformatf("%s busy", tag), 64'(busy_ok), 64'd1);
    check($sformatf("%s busy in done", tag), 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    check($sformatf("%s single done", tag), 64'(bus.done_o), 64'd0);
  endtask

  initial begin
    int cyc;
    int n;
    int t1;
    int t2;
    int dones;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] mid;

    checks       = 0;
    fails        = 0;
    rst_n        = 1'b0;
    bus.start_i  = 1'b0;
    bus.op_i     = 3'b000;
    bus.a_i      = '0;
    bus.b_i      = '0;
    bus8.start_i = 1'b0;
    bus8.op_i    = 3'b000;
    bus8.a_i     = '0;
    bus8.b_i     = '0;

    repeat (2) @(negedge clk);
    check("reset busy", 64'(bus.busy_o), 64'd0);
    check("reset done", 64'(bus.done_o), 64'd0);
    check("reset result", 64'(bus.result_o), 64'd0);
    rst_n = 1'b1;

    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "MUL 7*-3");
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "MULH");
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "MULHSU");
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "MULHU");
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "DIV -7/2");
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "REM -7/2");
    do_op(3'b101, 32'd100, 32'd7, 32'd14, 34, "DIVU 100/7");
    do_op(3'b111, 32'd100, 32'd7, 32'd2, 34, "REMU 100/7");
    do_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "DIVU by zero");
    do_op(3'b110, 32'd5, 32'd0, 32'd5, 2, "REM by zero");
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "DIV overflow");
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, "REM overflow");

    // start_i held high: back-to-back ops, old result held until the new done
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = 3'b000;
    bus.a_i     = 32'd3;
    bus.b_i     = 32'd5;
    @(posedge clk);
    cyc = 0;
    n   = 0;
    t1  = 0;
    t2  = 0;
    r1  = '0;
    r2  = '0;
    mid = '0;
    while (n < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 50) mid = bus.result_o;
      if (bus.done_o) begin
        n++;
        if (n == 1) begin
          t1 = cyc;
          r1 = bus.result_o;
          bus.a_i = 32'd4;
        end else begin
          t2 = cyc;
          r2 = bus.result_o;
          bus.start_i = 1'b0;
        end
      end
    end
    check("b2b first done", 64'(t1), 64'd34);
    check("b2b first result", 64'(r1), 64'd15);
    check("b2b held result", 64'(mid), 64'd15);
    check("b2b second done", 64'(t2), 64'd68);
    check("b2b second result", 64'(r2), 64'd20);

    // Asynchronous reset in the middle of a DIV
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = 3'b100;
    bus.a_i     = 32'd1000;
    bus.b_i     = 32'd3;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst busy", 64'(bus.busy_o), 64'd0);
    check("rst done", 64'(bus.done_o), 64'd0);
    check("rst result", 64'(bus.result_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) dones++;
    end
    check("rst no done", 64'(dones), 64'd0);
    do_op(3'b000, 32'd3, 32'd4, 32'd12, 34, "MUL 3*4 after reset");

    // XLEN=8 instance: MUL 7 * -3
    @(negedge clk);
    bus8.start_i = 1'b1;
    bus8.op_i    = 3'b000;
    bus8.a_i     = 8'd7;
    bus8.b_i     = 8'hFD;
    @(posedge clk);
    #1;
    bus8.start_i = 1'b0;
    cyc = 0;
    while (!bus8.done_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("x8 latency", 64'(cyc), 64'd10);
    check("x8 result", 64'(bus8.result_o), 64'hEB);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
